// File: rtl/aibio_pvtmon_seq_ctrl.sv
// PVT-monitor sensor sequencer: selects each enabled sensor, settles, counts oscillator edges per window.
// Optional build macro PVTMON_AVG_EN: average four consecutive count windows per channel.
module aibio_pvtmon_seq_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int WINDOW_CYC = 256,
    parameter int CNT_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vdd,
    input  logic             vss,
    input  logic             start,
    input  logic             cont_mode,
    input  logic [7:0]       ch_mask,
    input  logic             osc_in,
    output logic [2:0]       sel,
    output logic             osc_en,
    output logic             busy,
    output logic             result_vld,
    output logic [2:0]       result_ch,
    output logic [CNT_W-1:0] result_cnt,
    output logic             sweep_done
);

    localparam int CYC_W = $clog2(SETTLE_CYC > WINDOW_CYC ? SETTLE_CYC : WINDOW_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_COUNT,
        S_REPORT
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         mask_q;
    logic               mode_q;
    logic [2:0]         ptr;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [CNT_W-1:0]   edge_cnt, cnt_inc;
    logic               osc_s1, osc_s2, osc_prev, osc_edge;
    logic               last_cyc, last_win, has_next;
    logic [7:0]         remaining;
    logic               unused_supply;

    assign unused_supply = vdd ^ vss;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest_bit = 3'(i);
    endfunction

    assign osc_edge  = osc_s2 & ~osc_prev;
    assign last_cyc  = (cyc_cnt == '0);
    assign remaining = mask_q & (8'hFE << ptr);
    assign has_next  = |remaining;
    assign cnt_inc   = (osc_edge && edge_cnt != {CNT_W{1'b1}}) ? edge_cnt + 1'b1 : edge_cnt;
    assign busy      = (state != S_IDLE);

`ifdef PVTMON_AVG_EN
    logic [1:0]       win_idx;
    logic [CNT_W+1:0] acc;
    assign last_win = (win_idx == 2'd3);
`else
    assign last_win = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start && |ch_mask) state_nxt = S_SELECT;
            S_SELECT: state_nxt = S_SETTLE;
            S_SETTLE: if (last_cyc) state_nxt = S_COUNT;
            S_COUNT:  if (last_cyc && last_win) state_nxt = S_REPORT;
            S_REPORT: state_nxt = (has_next || mode_q) ? S_SELECT : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            {osc_s1, osc_s2, osc_prev} <= '0;
            mask_q     <= '0;
            mode_q     <= 1'b0;
            ptr        <= '0;
            cyc_cnt    <= '0;
            edge_cnt   <= '0;
            sel        <= '0;
            osc_en     <= 1'b0;
            result_vld <= 1'b0;
            result_ch  <= '0;
            result_cnt <= '0;
            sweep_done <= 1'b0;
`ifdef PVTMON_AVG_EN
            win_idx    <= '0;
            acc        <= '0;
`endif
        end else begin
            osc_s1     <= osc_in;
            osc_s2     <= osc_s1;
            osc_prev   <= osc_s2;
            result_vld <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && |ch_mask) begin
                        mask_q <= ch_mask;
                        mode_q <= cont_mode;
                        ptr    <= lowest_bit(ch_mask);
                    end
                end
                S_SELECT: begin
                    sel      <= ptr;
                    osc_en   <= 1'b1;
                    cyc_cnt  <= CYC_W'(SETTLE_CYC - 1);
                    edge_cnt <= '0;
                end
                S_SETTLE: begin
                    edge_cnt <= '0;
`ifdef PVTMON_AVG_EN
                    win_idx  <= '0;
                    acc      <= '0;
`endif
                    cyc_cnt  <= last_cyc ? CYC_W'(WINDOW_CYC - 1) : cyc_cnt - 1'b1;
                end
                S_COUNT: begin
                    if (last_cyc) begin
`ifdef PVTMON_AVG_EN
                        // Each window saturates on its own before joining the sum.
                        acc      <= acc + {2'b00, cnt_inc};
                        edge_cnt <= '0;
                        win_idx  <= win_idx + 2'd1;
                        cyc_cnt  <= CYC_W'(WINDOW_CYC - 1);
`else
                        edge_cnt <= cnt_inc;
`endif
                    end else begin
                        edge_cnt <= cnt_inc;
                        cyc_cnt  <= cyc_cnt - 1'b1;
                    end
                end
                S_REPORT: begin
                    result_vld <= 1'b1;
                    result_ch  <= sel;
`ifdef PVTMON_AVG_EN
                    result_cnt <= acc[CNT_W+1:2];
`else
                    result_cnt <= edge_cnt;
`endif
                    if (has_next) begin
                        ptr <= lowest_bit(remaining);
                    end else begin
                        sweep_done <= 1'b1;
                        if (mode_q) ptr <= lowest_bit(mask_q);
                        else        osc_en <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aibio_pvtmon_seq_ctrl.sv
// Self-checking bench for aibio_pvtmon_seq_ctrl: randomized sweeps against a channel-order / edge-rate model.
`timescale 1ns/1ps
module tb_aibio_pvtmon_seq_ctrl;

    localparam int S = 16;
    localparam int W = 256;
`ifdef PVTMON_AVG_EN
    localparam int NWIN = 4;
`else
    localparam int NWIN = 1;
`endif
    localparam int LAT = 2 + S + W * NWIN;

    logic clk = 1'b0, rst = 1'b1;
    logic vdd = 1'b1, vss = 1'b0;
    logic start = 1'b0, cont_mode = 1'b0, osc_in = 1'b0;
    logic [7:0] ch_mask = '0;
    logic [2:0] sel, result_ch;
    logic osc_en, busy, result_vld, sweep_done;
    logic [11:0] result_cnt;

    logic start_s = 1'b0, osc_s = 1'b0;
    logic [7:0] mask_s = '0;
    logic [2:0] sel_s, result_ch_s;
    logic osc_en_s, busy_s, result_vld_s, sweep_done_s;
    logic [5:0] result_cnt_s;

    int osc_half = 40;
    int tests_run = 0, tests_failed = 0;

    always #5 clk = ~clk;

    initial begin
        #3;
        forever begin
            #(osc_half) osc_in = ~osc_in;
        end
    end

    initial begin
        #3;
        forever #10 osc_s = ~osc_s;
    end

    aibio_pvtmon_seq_ctrl #(.SETTLE_CYC(S), .WINDOW_CYC(W), .CNT_W(12)) dut (
        .clk(clk), .rst(rst), .vdd(vdd), .vss(vss), .start(start), .cont_mode(cont_mode),
        .ch_mask(ch_mask), .osc_in(osc_in), .sel(sel), .osc_en(osc_en), .busy(busy),
        .result_vld(result_vld), .result_ch(result_ch), .result_cnt(result_cnt), .sweep_done(sweep_done)
    );

    aibio_pvtmon_seq_ctrl #(.SETTLE_CYC(S), .WINDOW_CYC(W), .CNT_W(6)) dut_sat (
        .clk(clk), .rst(rst), .vdd(vdd), .vss(vss), .start(start_s), .cont_mode(1'b0),
        .ch_mask(mask_s), .osc_in(osc_s), .sel(sel_s), .osc_en(osc_en_s), .busy(busy_s),
        .result_vld(result_vld_s), .result_ch(result_ch_s), .result_cnt(result_cnt_s), .sweep_done(sweep_done_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_period(input int period);
        osc_half = period * 5;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({sel, osc_en, busy, result_vld, result_ch, result_cnt, sweep_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_main: got sel=%0d osc_en=%b busy=%b vld=%b ch=%0d cnt=%0d done=%b, want all 0",
                     sel, osc_en, busy, result_vld, result_ch, result_cnt, sweep_done);
        end
        tests_run++;
        if ({sel_s, osc_en_s, busy_s, result_vld_s, result_ch_s, result_cnt_s, sweep_done_s} !== '0) begin
            tests_failed++;
            $display("FAIL reset_sat: got nonzero outputs, want all 0");
        end
        rst = 1'b0;
        tick();
    endtask

    // One non-continuous sweep: results expected in ascending order of set mask bits, LAT apart,
    // each count near W/period edges; optionally pulses start mid-sweep with a different setup.
    task automatic run_sweep(input logic [7:0] mask, input int period, input bit inject, input string tag);
        int exp_ch[$];
        int cyc, nres, ndone, budget, lo, hi;
        bit bad_sel;
        for (int c = 0; c < 8; c++) if (mask[c]) exp_ch.push_back(c);
        set_period(period);
        lo = W / period - 1;
        hi = W / period + 1;
        ch_mask = mask; cont_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; nres = 0; ndone = 0; bad_sel = 1'b0; budget = LAT * 9 + 20;
        while (busy === 1'b1 && cyc < budget) begin
            if (inject && cyc == 100) begin
                start = 1'b1; ch_mask = ~mask; cont_mode = 1'b1;
            end else begin
                start = 1'b0; ch_mask = mask; cont_mode = 1'b0;
            end
            tick();
            cyc++;
            if (osc_en === 1'b1 && !mask[sel]) bad_sel = 1'b1;
            if (sweep_done === 1'b1) ndone++;
            if (result_vld === 1'b1) begin
                tests_run++;
                if (nres >= exp_ch.size()) begin
                    tests_failed++;
                    $display("FAIL %s extra_result: got ch=%0d at cyc %0d, want no more results", tag, result_ch, cyc);
                end else if ($isunknown(result_cnt) || result_ch !== 3'(exp_ch[nres]) || cyc != LAT * (nres + 1)
                             || result_cnt < 12'(lo) || result_cnt > 12'(hi)
                             || sweep_done !== (nres == exp_ch.size() - 1)) begin
                    tests_failed++;
                    $display("FAIL %s result%0d: got ch=%0d cnt=%0d cyc=%0d done=%b, want ch=%0d cnt=%0d..%0d cyc=%0d done=%b",
                             tag, nres, result_ch, result_cnt, cyc, sweep_done, exp_ch[nres], lo, hi,
                             LAT * (nres + 1), nres == exp_ch.size() - 1);
                end
                nres++;
            end
        end
        start = 1'b0; ch_mask = mask; cont_mode = 1'b0;
        tests_run++;
        if (cyc >= budget || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s end_idle: got busy=%b after %0d cycles, want idle within %0d", tag, busy, cyc, budget);
        end
        tests_run++;
        if (nres != exp_ch.size() || ndone != 1) begin
            tests_failed++;
            $display("FAIL %s totals: got %0d results %0d done, want %0d results 1 done", tag, nres, ndone, exp_ch.size());
        end
        tests_run++;
        if (bad_sel) begin
            tests_failed++;
            $display("FAIL %s sel_masked: got sel on disabled channel, want only mask %h", tag, mask);
        end
    endtask

    task automatic test_single();
        run_sweep(8'h01, 8, 1'b0, "single");
        tests_run++;
        if (sel !== 3'd0 || osc_en !== 1'b0 || result_ch !== 3'd0) begin
            tests_failed++;
            $display("FAIL single_after: got sel=%0d osc_en=%b ch=%0d, want 0 0 0", sel, osc_en, result_ch);
        end
    endtask

    task automatic test_mask_a5_with_busy_start();
        run_sweep(8'hA5, 8, 1'b1, "mask_a5");
    endtask

    task automatic test_random_sweeps();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] m;
            int p;
            m = 8'($urandom_range(1, 255));
            p = 2 * int'($urandom_range(2, 16));
            run_sweep(m, p, 1'b0, $sformatf("rand%0d_m%02h_p%0d", it, m, p));
        end
    endtask

    task automatic test_zero_mask();
        bit saw_busy, saw_vld;
        saw_busy = 1'b0; saw_vld = 1'b0;
        ch_mask = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (300) begin
            if (busy !== 1'b0) saw_busy = 1'b1;
            if (result_vld !== 1'b0) saw_vld = 1'b1;
            tick();
        end
        tests_run++;
        if (saw_busy) begin
            tests_failed++;
            $display("FAIL zero_mask_busy: got busy=1, want 0");
        end
        tests_run++;
        if (saw_vld) begin
            tests_failed++;
            $display("FAIL zero_mask_vld: got result_vld=1, want 0");
        end
    endtask

    task automatic test_saturate();
        int cyc;
        mask_s = 8'h10; start_s = 1'b1;
        tick();
        start_s = 1'b0;
        cyc = 0;
        while (result_vld_s !== 1'b1 && cyc < LAT + 20) begin
            tick();
            cyc++;
        end
        tests_run++;
        if (result_vld_s !== 1'b1 || cyc != LAT || result_ch_s !== 3'd4 || result_cnt_s !== 6'd63
            || sweep_done_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturate: got vld=%b cyc=%0d ch=%0d cnt=%0d done=%b, want 1 %0d 4 63 1",
                     result_vld_s, cyc, result_ch_s, result_cnt_s, sweep_done_s, LAT);
        end
        tick();
        tests_run++;
        if (busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL saturate_idle: got busy=%b, want 0", busy_s);
        end
    endtask

    task automatic test_continuous_and_reset();
        int cyc, nres;
        bit saw_vld;
        set_period(8);
        ch_mask = 8'h80; cont_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; cont_mode = 1'b0; ch_mask = 8'h01;
        cyc = 0; nres = 0;
        while (nres < 3 && cyc < 3 * LAT + 50) begin
            tick();
            cyc++;
            if (result_vld === 1'b1) begin
                tests_run++;
                if (cyc != LAT * (nres + 1) || result_ch !== 3'd7 || sweep_done !== 1'b1 || sel !== 3'd7
                    || $isunknown(result_cnt) || result_cnt < 12'(W / 8 - 1) || result_cnt > 12'(W / 8 + 1)) begin
                    tests_failed++;
                    $display("FAIL cont result%0d: got cyc=%0d ch=%0d done=%b cnt=%0d, want cyc=%0d ch=7 done=1 cnt=%0d..%0d",
                             nres, cyc, result_ch, sweep_done, result_cnt, LAT * (nres + 1), W / 8 - 1, W / 8 + 1);
                end
                nres++;
            end
        end
        tests_run++;
        if (nres != 3 || busy !== 1'b1 || osc_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL cont_running: got %0d results busy=%b osc_en=%b, want 3 1 1", nres, busy, osc_en);
        end
        while (cyc < 3 * LAT + S + 100) begin
            tick();
            cyc++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({sel, osc_en, busy, result_vld, result_ch, result_cnt, sweep_done} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_count: got sel=%0d osc_en=%b busy=%b vld=%b ch=%0d cnt=%0d done=%b, want all 0",
                     sel, osc_en, busy, result_vld, result_ch, result_cnt, sweep_done);
        end
        saw_vld = 1'b0;
        repeat (LAT + 20) begin
            tick();
            if (result_vld !== 1'b0 || busy !== 1'b0) saw_vld = 1'b1;
        end
        tests_run++;
        if (saw_vld) begin
            tests_failed++;
            $display("FAIL rst_quiet: got activity after reset, want idle with no result");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mask_a5_with_busy_start();
        test_zero_mask();
        test_saturate();
        test_random_sweeps();
        test_continuous_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
